// File: rtl/tile_cl_dir_resp_if.sv
`default_nettype none
// tile_cl_dir_resp_if: request stream, memory port and response bus of the
// tile cache-line directory responder. master = tile/memory side, slave = responder.
interface tile_cl_dir_resp_if;
  logic         req_en;
  logic [36:0]  req_addr;
  logic [527:0] req_data;
  logic [41:0]  req_size;
  logic         req_expun;
  logic [3:0]   req_src_XY;
  logic         req_full;
  logic         err_ovf;
  logic         mem_rd_en;
  logic [36:0]  mem_rd_addr;
  logic         mem_rd_valid;
  logic [527:0] mem_rd_data;
  logic         mem_wr_en;
  logic [36:0]  mem_wr_addr;
  logic [527:0] mem_wr_data;
  logic         fiq_en;
  logic [36:0]  fiq_addr;
  logic [527:0] fiq_data_out;
  logic [39:0]  fiq_phy_fwd;
  logic         fiq_want_shared;
  logic         fiq_want_exclusive;
  logic         fiq_wb;
  logic         fiq_fwd;
  logic [3:0]   fiq_fwd_XY;

  modport master (
    output req_en, req_addr, req_data, req_size, req_expun, req_src_XY,
           mem_rd_valid, mem_rd_data,
    input  req_full, err_ovf, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
           mem_wr_data, fiq_en, fiq_addr, fiq_data_out, fiq_phy_fwd,
           fiq_want_shared, fiq_want_exclusive, fiq_wb, fiq_fwd, fiq_fwd_XY
  );

  modport slave (
    input  req_en, req_addr, req_data, req_size, req_expun, req_src_XY,
           mem_rd_valid, mem_rd_data,
    output req_full, err_ovf, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
           mem_wr_data, fiq_en, fiq_addr, fiq_data_out, fiq_phy_fwd,
           fiq_want_shared, fiq_want_exclusive, fiq_wb, fiq_fwd, fiq_fwd_XY
  );
endinterface
`default_nettype wire

// File: rtl/tile_cl_dir_resp.sv
`default_nettype none
// tile_cl_dir_resp: 4-deep request queue, exclusive-owner directory and
// responder FSM returning fill / forward / write-back-ack responses.
module tile_cl_dir_resp #(
  parameter int tile_X = 0,
  parameter int tile_Y = 0,
  parameter int DIR_N  = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  tile_cl_dir_resp_if.slave  bus
);
  localparam int c_IW = (DIR_N > 1) ? $clog2(DIR_N) : 1;

  typedef struct packed {
    logic [36:0]  addr;
    logic [527:0] data;
    logic [41:0]  size;
    logic         expun;
    logic [3:0]   src;
  } req_t;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MEMRD, S_RESP, S_WB} state_t;

  req_t        r_q [4];
  logic [1:0]  r_wp, r_rp;
  logic [2:0]  r_cnt;
  logic        r_full, r_ovf;
  state_t      r_state;
  req_t        r_w;
  logic        r_hit;
  logic [c_IW-1:0] r_hit_idx;

  logic [DIR_N-1:0] r_dir_v;
  logic [36:0]      r_dir_addr [DIR_N];
  logic [3:0]       r_dir_own  [DIR_N];

  logic         r_mem_rd_en, r_mem_wr_en, r_fiq_en;
  logic [36:0]  r_mem_rd_addr, r_mem_wr_addr, r_fiq_addr;
  logic [527:0] r_mem_wr_data, r_fiq_data;
  logic [39:0]  r_fiq_phy;
  logic         r_fiq_ws, r_fiq_wx, r_fiq_wb, r_fiq_fwd;
  logic [3:0]   r_fiq_xy;

  logic         w_push, w_pop, w_excl;
  logic [2:0]   w_cnt_nxt;
  req_t         w_in;
  logic         w_hit, w_free_ok;
  logic [c_IW-1:0] w_hit_idx, w_free_idx;
  logic [4:0]   w_unused_bits;

  assign w_in      = '{addr: bus.req_addr, data: bus.req_data, size: bus.req_size,
                       expun: bus.req_expun, src: bus.req_src_XY};
  assign w_push    = bus.req_en & ~r_full;
  assign w_pop     = (r_state == S_IDLE) && (r_cnt != 3'd0);
  assign w_cnt_nxt = r_cnt + {2'b00, w_push} - {2'b00, w_pop};
  // Exclusive bit wins over shared; shared bit alone never changes behaviour.
  assign w_excl    = r_w.size[40];
  assign w_unused_bits = {r_w.size[41], 2'(tile_Y), 2'(tile_X)};

  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free_ok  = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < DIR_N; i++) begin
      if (r_dir_v[i] && (r_dir_addr[i] == r_w.addr)) begin
        w_hit     = 1'b1;
        w_hit_idx = i[c_IW-1:0];
      end
    end
    for (int i = DIR_N - 1; i >= 0; i--) begin
      if (!r_dir_v[i]) begin
        w_free_ok  = 1'b1;
        w_free_idx = i[c_IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wp] <= w_in;
    if (rst) begin
      r_wp   <= 2'd0;
      r_rp   <= 2'd0;
      r_cnt  <= 3'd0;
      r_full <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == 3'd4);
      if (bus.req_en && r_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_dir_v       <= '0;
      r_hit         <= 1'b0;
      r_hit_idx     <= '0;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_fiq_en      <= 1'b0;
      r_fiq_addr    <= '0;
      r_fiq_data    <= '0;
      r_fiq_phy     <= '0;
      r_fiq_ws      <= 1'b0;
      r_fiq_wx      <= 1'b0;
      r_fiq_wb      <= 1'b0;
      r_fiq_fwd     <= 1'b0;
      r_fiq_xy      <= '0;
    end else begin
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_fiq_en    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_cnt != 3'd0) begin
            r_w     <= r_q[r_rp];
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_hit      <= w_hit;
          r_hit_idx  <= w_hit_idx;
          // Response payload defaults; branches below override what differs.
          r_fiq_addr <= r_w.addr;
          r_fiq_phy  <= r_w.size[39:0];
          r_fiq_data <= '0;
          r_fiq_ws   <= 1'b0;
          r_fiq_wx   <= 1'b0;
          r_fiq_wb   <= 1'b0;
          r_fiq_fwd  <= 1'b0;
          r_fiq_xy   <= r_w.src;
          if (r_w.expun) begin
            r_state       <= S_WB;
            r_mem_wr_en   <= 1'b1;
            r_mem_wr_addr <= r_w.addr;
            r_mem_wr_data <= r_w.data;
            r_fiq_en      <= 1'b1;
            r_fiq_wb      <= 1'b1;
            if (w_hit && (r_dir_own[w_hit_idx] == r_w.src)) r_dir_v[w_hit_idx] <= 1'b0;
          end else if (w_hit && (r_dir_own[w_hit_idx] != r_w.src)) begin
            r_state   <= S_RESP;
            r_fiq_en  <= 1'b1;
            r_fiq_fwd <= 1'b1;
            r_fiq_xy  <= r_dir_own[w_hit_idx];
            r_fiq_ws  <= ~w_excl;
            r_fiq_wx  <= w_excl;
            if (w_excl) r_dir_own[w_hit_idx] <= r_w.src;
            else        r_dir_v[w_hit_idx]   <= 1'b0;
          end else begin
            r_state       <= S_MEMRD;
            r_mem_rd_en   <= 1'b1;
            r_mem_rd_addr <= r_w.addr;
          end
        end
        S_MEMRD: begin
          if (bus.mem_rd_valid) begin
            r_state    <= S_RESP;
            r_fiq_en   <= 1'b1;
            r_fiq_data <= bus.mem_rd_data;
            if (!w_excl) begin
              r_fiq_ws <= 1'b1;
            end else if (r_hit) begin
              r_fiq_wx <= 1'b1;
              r_dir_own[r_hit_idx] <= r_w.src;
            end else if (w_free_ok) begin
              r_fiq_wx <= 1'b1;
              r_dir_v[w_free_idx]    <= 1'b1;
              r_dir_addr[w_free_idx] <= r_w.addr;
              r_dir_own[w_free_idx]  <= r_w.src;
            end else begin
              r_fiq_ws <= 1'b1;
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_full           = r_full;
  assign bus.err_ovf            = r_ovf;
  assign bus.mem_rd_en          = r_mem_rd_en;
  assign bus.mem_rd_addr        = r_mem_rd_addr;
  assign bus.mem_wr_en          = r_mem_wr_en;
  assign bus.mem_wr_addr        = r_mem_wr_addr;
  assign bus.mem_wr_data        = r_mem_wr_data;
  assign bus.fiq_en             = r_fiq_en;
  assign bus.fiq_addr           = r_fiq_addr;
  assign bus.fiq_data_out       = r_fiq_data;
  assign bus.fiq_phy_fwd        = r_fiq_phy;
  assign bus.fiq_want_shared    = r_fiq_ws;
  assign bus.fiq_want_exclusive = r_fiq_wx;
  assign bus.fiq_wb             = r_fiq_wb;
  assign bus.fiq_fwd            = r_fiq_fwd;
  assign bus.fiq_fwd_XY         = r_fiq_xy;
endmodule
`default_nettype wire

// File: tb/tb_tile_cl_dir_resp.sv
`default_nettype none
// tb_tile_cl_dir_resp: directed and randomized requests checked against an
// ownership map (line address -> owner tile) of the directory.
module tb_tile_cl_dir_resp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tile_cl_dir_resp_if bus ();
  tile_cl_dir_resp #(.tile_X(0), .tile_Y(0), .DIR_N(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nchk = 0;
  int nfail = 0;
  int own [bit [36:0]];

  task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [527:0] rand_line();
    logic [527:0] v;
    v = '0;
    for (int i = 0; i < 17; i++) v = (v << 32) | 528'($urandom);
    return v;
  endfunction

  function automatic logic [41:0] mk_size(input bit sh, input bit ex);
    return {sh, ex, 8'h00, 32'($urandom)};
  endfunction

  // One complete request: req_en in cycle 0, memory answers in cycle 3+lat.
  task automatic do_req(input logic [36:0] a, input logic [41:0] sz, input logic ex,
                        input logic [3:0] src, input int lat);
    logic [527:0] wd, rd, f_data, wr_data;
    logic [36:0]  rd_addr, wr_addr, f_addr;
    logic [39:0]  f_phy;
    logic [3:0]   exp_xy, f_xy;
    logic         f_ws, f_wx, f_wb, f_fwd;
    bit excl, hit, fwd, memrd, exp_s, exp_x, done;
    int k, c_rd, c_wr, c_fiq, n_rd, n_wr;
    wd = rand_line(); rd = rand_line();
    excl = sz[40]; hit = own.exists(a[36:0]);
    fwd = 0; memrd = 0; exp_xy = src; exp_s = 0; exp_x = 0;
    if (ex) begin
      if (hit && own[a] == int'(src)) own.delete(a);
    end else if (hit && own[a] != int'(src)) begin
      fwd = 1; exp_xy = 4'(own[a]);
      if (excl) own[a] = int'(src); else own.delete(a);
    end else begin
      memrd = 1;
      if (!excl) exp_s = 1;
      else if (hit) exp_x = 1;
      else if (own.num() < 8) begin exp_x = 1; own[a] = int'(src); end
      else exp_s = 1;
    end
    k = 3 + lat;
    c_rd = -1; c_wr = -1; c_fiq = -1; n_rd = 0; n_wr = 0; done = 0;
    f_data = 'x; f_addr = 'x; f_phy = 'x; f_xy = 'x; f_ws = 'x; f_wx = 'x; f_wb = 'x; f_fwd = 'x;
    rd_addr = 'x; wr_addr = 'x; wr_data = 'x;
    @(posedge clk); #1;
    bus.req_en = 1'b1; bus.req_addr = a; bus.req_data = wd; bus.req_size = sz;
    bus.req_expun = ex; bus.req_src_XY = src;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      bus.req_en = 1'b0;
      bus.mem_rd_valid = memrd && (c == k);
      bus.mem_rd_data = (c == k) ? rd : rand_line();
      @(negedge clk);
      if (bus.mem_rd_en) begin n_rd++; if (c_rd < 0) begin c_rd = c; rd_addr = bus.mem_rd_addr; end end
      if (bus.mem_wr_en) begin n_wr++; c_wr = c; wr_addr = bus.mem_wr_addr; wr_data = bus.mem_wr_data; end
      if (c_fiq >= 0 && c == c_fiq + 1) begin
        chk("fiq_pulse_len", bus.fiq_en, 0);
        done = 1;
      end else if (bus.fiq_en && c_fiq < 0) begin
        c_fiq = c; f_data = bus.fiq_data_out; f_addr = bus.fiq_addr; f_phy = bus.fiq_phy_fwd;
        f_xy = bus.fiq_fwd_XY; f_ws = bus.fiq_want_shared; f_wx = bus.fiq_want_exclusive;
        f_wb = bus.fiq_wb; f_fwd = bus.fiq_fwd;
      end
    end
    bus.mem_rd_valid = 1'b0;
    chk("fiq_cycle", c_fiq, memrd ? k + 1 : 3);
    chk("mem_rd_count", n_rd, memrd ? 1 : 0);
    if (memrd) begin
      chk("mem_rd_cycle", c_rd, 3);
      chk("mem_rd_addr", rd_addr, a);
    end
    chk("mem_wr_count", n_wr, ex ? 1 : 0);
    if (ex) begin
      chk("mem_wr_cycle", c_wr, 3);
      chk("mem_wr_addr", wr_addr, a);
      chk("mem_wr_data", wr_data, wd);
    end
    chk("fiq_addr", f_addr, a);
    chk("fiq_data", f_data, memrd ? rd : '0);
    chk("fiq_phy", f_phy, sz[39:0]);
    chk("fiq_wb", f_wb, ex);
    chk("fiq_fwd", f_fwd, fwd);
    chk("fiq_fwd_XY", f_xy, exp_xy);
    if (!fwd) begin
      chk("fiq_want_shared", f_ws, exp_s);
      chk("fiq_want_excl", f_wx, exp_x);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_en = 0; bus.req_addr = '0; bus.req_data = '0; bus.req_size = '0;
    bus.req_expun = 0; bus.req_src_XY = '0; bus.mem_rd_valid = 0; bus.mem_rd_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_fiq_en", bus.fiq_en, 0);
    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_mem_wr_en", bus.mem_wr_en, 0);
    chk("rst_req_full", bus.req_full, 0);
    chk("rst_err_ovf", bus.err_ovf, 0);
    chk("rst_fiq_data", bus.fiq_data_out, 0);
    chk("rst_fiq_flags", {bus.fiq_want_shared, bus.fiq_want_exclusive, bus.fiq_wb, bus.fiq_fwd, bus.fiq_fwd_XY}, 0);

    // Shared miss, memory answers in cycle 6.
    do_req(37'h100, mk_size(1, 0), 0, 4'h5, 3);
    // Exclusive then forward, write-back, re-read from memory.
    do_req(37'h200, mk_size(0, 1), 0, 4'h1, 1);
    do_req(37'h200, mk_size(0, 1), 0, 4'h2, 2);
    do_req(37'h200, mk_size(0, 0), 1, 4'h2, 1);
    do_req(37'h200, mk_size(1, 1), 0, 4'h3, 1);
    do_req(37'h200, mk_size(0, 0), 1, 4'h3, 1);
    // Fill the directory, overflow by one, then probe every entry via a forward.
    for (int i = 0; i < 8; i++) do_req(37'h300 + 37'(i), mk_size(0, 1), 0, 4'(i), 1);
    do_req(37'h3FF, mk_size(0, 1), 0, 4'h9, 2);
    for (int i = 0; i < 8; i++) do_req(37'h300 + 37'(i), mk_size(1, 0), 0, 4'hF, 1);

    for (int n = 0; n < 80; n++)
      do_req(37'h400 + 37'($urandom_range(0, 11)), {2'($urandom), 8'h00, 32'($urandom)},
             1'($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)), $urandom_range(1, 4));

    // Six back-to-back shared misses with memory stalled: count reaches 4
    // at the end of cycle 4 (first entry already popped), so full from cycle 5.
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      bus.req_en = (j < 6);
      bus.req_addr = 37'h1F000 + 37'(j); bus.req_size = mk_size(1, 0);
      bus.req_expun = 0; bus.req_src_XY = 4'h7; bus.req_data = rand_line();
      @(negedge clk);
      chk("ovf_req_full", bus.req_full, j >= 5);
      chk("ovf_err_ovf", bus.err_ovf, j >= 6);
      chk("ovf_no_fiq", bus.fiq_en, 0);
    end
    bus.req_en = 0;

    // Reset while waiting in the memory read, then a stale memory response.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    own.delete();
    bus.mem_rd_valid = 1'b1; bus.mem_rd_data = rand_line();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("rr_fiq_en", bus.fiq_en, 0);
      chk("rr_mem", {bus.mem_rd_en, bus.mem_wr_en, bus.req_full, bus.err_ovf}, 0);
      chk("rr_fiq_data", bus.fiq_data_out, 0);
      @(posedge clk); #1 bus.mem_rd_valid = 1'b0;
    end

    do_req(37'h500, mk_size(0, 1), 0, 4'h6, 2);
    do_req(37'h500, mk_size(1, 0), 0, 4'h8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tile_cl_dir_resp.md
# tile_cl_dir_resp

Tile-local responder at the far end of the mesh cache-line request path. It accepts line requests from the tile FIFO (`reqmort_*` / `outen` stream), tracks exclusive ownership in a small directory, reads or writes backing memory, and returns fill / forward / write-back-ack responses on the `fiq_*` interface. It is instantiated once per tile, between the XY FIFO and the tile's memory port.

## Interface
- `tile_X`, default 0: this tile's X coordinate (2 LSBs used).
- `tile_Y`, default 0: this tile's Y coordinate (2 LSBs used).
- `DIR_N`, default 8: number of directory entries, power of two, 2..16.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_en` in 1: request valid; this is the FIFO `outen`.
- `req_addr` in 37: line address.
- `req_data` in 528: line data, 8×66 bits.
- `req_size` in 42: request size; [41]=shared, [40]=exclusive, [39:0]=phy.
- `req_expun` in 1: request is an eviction / write-back.
- `req_src_XY` in 4: requester tile; {Y[1:0],X[1:0]}.
- `req_full` out 1: input queue holds 4 entries; `req_en` is not allowed while high.
- `err_ovf` out 1: sticky; set when `req_en` arrives while `req_full` is high.
- `mem_rd_en` out 1: one-cycle memory read request.
- `mem_rd_addr` out 37: read address.
- `mem_rd_valid` in 1: read data valid.
- `mem_rd_data` in 528: read data.
- `mem_wr_en` out 1: one-cycle memory write.
- `mem_wr_addr` out 37: write address.
- `mem_wr_data` out 528: write data.
- `fiq_en` out 1: response valid, one-cycle pulse.
- `fiq_addr` out 37: response line address.
- `fiq_data_out` out 528: fill data; 0 for forwards and acks.
- `fiq_phy_fwd` out 40: `req_size[39:0]` echoed.
- `fiq_want_shared` out 1: granted shared.
- `fiq_want_exclusive` out 1: granted exclusive.
- `fiq_wb` out 1: response is a write-back ack.
- `fiq_fwd` out 1: request forwarded to the current owner.
- `fiq_fwd_XY` out 4: owner tile when `fiq_fwd`=1, else `req_src_XY`.

## Operation
- Input queue: 4-entry circular FIFO of {addr, data, size, expun, src}.
  - 2-bit read and write pointers wrap modulo 4; 3-bit count.
  - Push on `req_en & ~req_full`. A push while full is dropped and sets `err_ovf`.
  - Pop happens in IDLE.
  - Push and pop in the same cycle leave the count unchanged.
- Directory: `DIR_N` entries of {valid, addr[36:0], owner[3:0]}. Every valid entry is an exclusive owner. Lines with no entry are memory-owned or shared.
- FSM states: IDLE, LOOKUP, MEMRD, RESP, WB.
  - **IDLE:** if the queue is non-empty, latch the head into the working register, pop, and go to LOOKUP.
  - **LOOKUP:** one cycle. Fully associative compare of `addr` against all valid entries (at most one hit).
    - expun → WB.
    - Hit with owner ≠ src → RESP, forward case.
    - Otherwise → MEMRD.
  - **MEMRD:** `mem_rd_en`=1 in the first MEMRD cycle only, with `mem_rd_addr`=addr. Wait for `mem_rd_valid`, capture the data, then go to RESP.
  - **RESP:** `fiq_en`=1 for one cycle, then go to IDLE. Outputs and directory update by case:
    - **Forward:** `fiq_fwd`=1, `fiq_fwd_XY`=owner, data 0.
      - Exclusive request: entry owner ← src.
      - Shared request: entry cleared.
    - **Exclusive grant:**
      - On a hit, owner ← src.
      - On a miss, allocate the lowest-index free entry.
      - If no entry is free, downgrade: `fiq_want_shared`=1, `fiq_want_exclusive`=0, no allocation.
    - **Shared grant:** `fiq_want_shared`=1, no directory change.
  - **WB:** one cycle, then go to IDLE.
    - `mem_wr_en`=1 with addr/data.
    - Same cycle: `fiq_en`=1, `fiq_wb`=1, `fiq_data_out`=0.
    - Entry matching addr is cleared only if its owner == src.
- Request class:
  - `req_size[40]`=1 → exclusive; this wins when both [41] and [40] are set.
  - Otherwise → shared. This includes both bits being 0.
  - `req_expun` overrides both.
- `mem_rd_valid` outside MEMRD is ignored.

## Timing
- Reset: state IDLE, queue empty, all directory entries invalid, `err_ovf`=0, and every output 0, except `req_full`=0.
- Reset asserted mid-operation aborts the current request. A memory response arriving after reset is ignored.
- All outputs are registered.
- `req_en` in cycle 0 leads to IDLE pop in cycle 1 and LOOKUP in cycle 2.
  - Forward: `fiq_en` in cycle 3.
  - Write-back: `mem_wr_en` and `fiq_en` in cycle 3.
  - Memory read: `mem_rd_en` in cycle 3. `mem_rd_valid` in cycle k≥4 gives `fiq_en` in cycle k+1.
- Throughput: one request in flight. Minimum 3 cycles per request (IDLE, LOOKUP, RESP/WB).
- `req_full` reflects the count at the start of the cycle. A pop in the same cycle does not free the slot until the next cycle.

## Test plan
- **Shared miss:** `req_en` with addr=0x100, size[41]=1, src=4'h5; memory returns data D in cycle 6.
  - `mem_rd_en` in cycle 3.
  - `fiq_en` in cycle 7 with data=D, `want_shared`=1, `fwd`=0.
  - Directory unchanged.
- **Exclusive then forward:** src=1 requests 0x200 exclusive, then src=2 requests 0x200 exclusive.
  - Second request: no `mem_rd_en`; `fiq_fwd`=1, `fiq_fwd_XY`=1.
  - Entry owner becomes 2.
- **Write-back:** owner 2 sends expun 0x200 with data W.
  - `mem_wr_en` with W and `fiq_wb`=1 in the same cycle.
  - Entry cleared.
  - A later exclusive request for 0x200 from src=3 reads memory.
- **Directory full:** 8 exclusive requests to distinct addresses fill the directory.
  - A 9th exclusive request returns `want_shared`=1, `want_exclusive`=0.
  - All 8 entries unchanged.
- **Queue overflow:** hold `mem_rd_valid`=0 and issue 6 back-to-back requests.
  - `req_full` rises after the 4th queued request.
  - The dropped push sets `err_ovf`=1; it stays set until `rst`.
- **Reset mid-read:** assert `rst` during MEMRD, then pulse `mem_rd_valid`.
  - No `fiq_en`; all outputs 0.
  - A fresh request afterwards completes normally.
